// File: rtl/stage_exec_ctrl.sv
// stage_exec_ctrl: per-stage execution controller. On a start pulse it issues a
// burst of BASE_BEATS >> level beats (floored at 1) with stall back-pressure,
// drains PIPE_DEPTH cycles, then holds a sticky done level for the sequencer.
// Optional watchdog: define STAGE_EXEC_TIMEOUT_EN to abandon a burst after
// TIMEOUT_CYCLES consecutive stalled RUN cycles (o_timeout otherwise tied low).
module stage_exec_ctrl #(
  parameter int LEVEL_WIDTH    = 4,
  parameter int BASE_BEATS     = 16,
  parameter int CNT_WIDTH      = 16,
  parameter int PIPE_DEPTH     = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [LEVEL_WIDTH-1:0] i_level,
  input  logic                   i_stall,
  output logic                   o_beat_valid,
  output logic [CNT_WIDTH-1:0]   o_beat_idx,
  output logic                   o_beat_last,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_proto_err,
  output logic                   o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Drain counter is sized for PIPE_DEPTH-1; kept at least 1 bit wide so a
  // zero-depth build still elaborates (the DRAIN state is then unreachable).
  localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] last_idx_q, last_idx_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic                 proto_q, proto_d;

  logic [CNT_WIDTH-1:0] n_beats;
  logic                 beat_fire;
  logic                 beat_final;
  logic                 timeout_hit;

  // Burst length for the level presented with the start pulse, floored at 1.
  always_comb begin
    n_beats = CNT_WIDTH'(BASE_BEATS) >> i_level;
    if (n_beats == '0) begin
      n_beats = CNT_WIDTH'(1);
    end
  end

  assign beat_fire  = (state_q == S_RUN) && !i_stall;
  assign beat_final = beat_fire && (cnt_q == last_idx_q);

`ifdef STAGE_EXEC_TIMEOUT_EN
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [WW-1:0] wdog_q, wdog_d;
  logic          timeout_q, timeout_d;

  // Watchdog: counts consecutive stalled RUN cycles, clears on any beat.
  always_comb begin
    wdog_d      = wdog_q;
    timeout_hit = 1'b0;
    if ((state_q != S_RUN) || beat_fire) begin
      wdog_d = '0;
    end else if (wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
      timeout_hit = 1'b1;
      wdog_d      = '0;
    end else begin
      wdog_d = wdog_q + 1'b1;
    end
    timeout_d = timeout_q | timeout_hit;
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  // Next-state logic: burst sequencing, drain countdown and protocol checking.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    drain_d    = drain_q;
    proto_d    = proto_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          last_idx_d = n_beats - 1'b1;
          drain_d    = '0;
        end
      end
      S_RUN: begin
        if (i_start) begin
          proto_d = 1'b1;
        end
        if (timeout_hit) begin
          state_d = S_DONE;
        end else if (beat_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (beat_final) begin
            state_d = (PIPE_DEPTH > 0) ? S_DRAIN : S_DONE;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (i_start) begin
          proto_d = 1'b1;
        end
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_idx_q <= '0;
      drain_q    <= '0;
      proto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
      drain_q    <= drain_d;
      proto_q    <= proto_d;
    end
  end

  assign o_beat_valid = beat_fire;
  assign o_beat_idx   = (state_q == S_RUN) ? cnt_q : '0;
  assign o_beat_last  = beat_final;
  assign o_busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign o_done       = (state_q == S_DONE);
  assign o_proto_err  = proto_q;

endmodule

// File: tb/tb_stage_exec_ctrl.sv
// Testbench for stage_exec_ctrl: directed latency scenarios plus randomized
// start/level/stall traffic against a burst-level reference model.
module tb_stage_exec_ctrl;

  localparam int LW   = 4;
  localparam int BASE = 16;
  localparam int CW   = 16;
  localparam int PD   = 3;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [LW-1:0] i_level;
  logic          i_stall;
  logic          o_beat_valid;
  logic [CW-1:0] o_beat_idx;
  logic          o_beat_last;
  logic          o_busy;
  logic          o_done;
  logic          o_proto_err;
  logic          o_timeout;

  stage_exec_ctrl #(
    .LEVEL_WIDTH    (LW),
    .BASE_BEATS     (BASE),
    .CNT_WIDTH      (CW),
    .PIPE_DEPTH     (PD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_level      (i_level),
    .i_stall      (i_stall),
    .o_beat_valid (o_beat_valid),
    .o_beat_idx   (o_beat_idx),
    .o_beat_last  (o_beat_last),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_proto_err  (o_proto_err),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Burst-level reference model: a burst is N beats; it is finished once all
  // beats are out and PD cycles have elapsed since the last one (or abandoned).
  bit m_active, m_abandon, m_proto, m_to;
  int m_n, m_issued, m_last_cyc, m_stallrun;
  int cyc;
  int rise1, rise2;
  bit prev_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", tag, got, exp, cyc, $time);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_abandon = 0; m_proto = 0; m_to = 0;
    m_n = 0; m_issued = 0; m_last_cyc = 0; m_stallrun = 0;
    rise1 = -1; rise2 = -1; prev_done = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, o_beat_valid, 0);
    chk({tag, "_idx"},   o_beat_idx,   0);
    chk({tag, "_last"},  o_beat_last,  0);
    chk({tag, "_busy"},  o_busy,       0);
    chk({tag, "_done"},  o_done,       0);
    chk({tag, "_proto"}, o_proto_err,  0);
    chk({tag, "_to"},    o_timeout,    0);
  endtask

  // Called at a falling edge; returns at a falling edge with cyc = 0.
  task automatic do_reset();
    i_start = 0; i_stall = 0; i_level = '0;
    rst_n = 0;
    #1;
    chk_all_zero("rst");
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_clear();
    cyc = 0;
  endtask

  // Asynchronous reset in the middle of a cycle: outputs must drop at once.
  task automatic mid_reset();
    i_start = 0; i_stall = 0;
    #2;
    rst_n = 0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1;
    model_clear();
    cyc = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance.
  task automatic step(input bit st, input int lvl, input bit sl);
    bit run, drain, busy, done, valid;
    i_start = st;
    i_level = lvl[LW-1:0];
    i_stall = sl;
    #1;
    run   = m_active && !m_abandon && (m_issued < m_n);
    drain = m_active && !m_abandon && (m_issued == m_n) && ((cyc - m_last_cyc) <= PD);
    busy  = run || drain;
    done  = m_active && !busy;
    valid = run && !sl;
    chk("beat_valid", o_beat_valid, valid);
    chk("beat_idx",   o_beat_idx,   run ? m_issued : 0);
    chk("beat_last",  o_beat_last,  valid && (m_issued == m_n - 1));
    chk("busy",       o_busy,       busy);
    chk("done",       o_done,       done);
    chk("proto_err",  o_proto_err,  m_proto);
    chk("timeout",    o_timeout,    m_to);
    if (o_done && !prev_done) begin
      if (rise1 < 0) rise1 = cyc;
      else if (rise2 < 0) rise2 = cyc;
    end
    prev_done = o_done;

    if (st && !busy) begin
      m_active = 1; m_abandon = 0; m_issued = 0; m_stallrun = 0;
      m_n = BASE >> lvl;
      if (m_n == 0) m_n = 1;
    end else begin
      if (st) m_proto = 1;
      if (run) begin
        if (!sl) begin
          m_issued++;
          m_stallrun = 0;
          if (m_issued == m_n) m_last_cyc = cyc;
        end else begin
          m_stallrun++;
`ifdef STAGE_EXEC_TIMEOUT_EN
          if (m_stallrun == TO) begin
            m_abandon = 1;
            m_to = 1;
          end
`endif
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst_n = 0; i_start = 0; i_stall = 0; i_level = '0;
    model_clear();
    cyc = 0;
    @(negedge clk);

    // Level 0 burst, illegal start at 6, restart from DONE at 25 with level 1.
    do_reset();
    for (int c = 0; c <= 40; c++) step(c == 0 || c == 6 || c == 25, (c == 25) ? 1 : 0, 0);
    chk("lvl0_done_rise", rise1, 20);
    chk("restart_done_rise", rise2, 37);

    // Level 2 with stalls on cycles 2..4.
    do_reset();
    for (int c = 0; c <= 14; c++) step(c == 0, 2, (c >= 2) && (c <= 4));
    chk("lvl2_stall_done_rise", rise1, 11);

    // Saturated level: a single beat.
    do_reset();
    for (int c = 0; c <= 7; c++) step(c == 0, 9, 0);
    chk("lvl9_done_rise", rise1, 5);

    // Stall held high from cycle 3.
    do_reset();
    for (int c = 0; c <= 20; c++) step(c == 0, 0, c >= 3);
`ifdef STAGE_EXEC_TIMEOUT_EN
    chk("timeout_done_rise", rise1, 11);
`else
    chk("stuck_no_done", rise1, 32'hFFFF_FFFF);
`endif

    // Reset asserted mid-burst, then no done afterwards.
    do_reset();
    for (int c = 0; c <= 5; c++) step(c == 0, 0, 0);
    mid_reset();
    for (int c = 0; c <= 5; c++) step(0, 0, 0);
    chk("no_partial_done", rise1, 32'hFFFF_FFFF);

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        mid_reset();
      end else begin
        step($urandom_range(0, 19) == 0, $urandom_range(0, 15), $urandom_range(0, 3) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stage_exec_ctrl.md
Name: stage_exec_ctrl

Overview:
- Per-stage execution controller placed directly downstream of the pipeline sequencer.
- Consumes one bit of the sequencer's one-hot start vector plus that stage's reduce level, and issues a bounded burst of datapath beats with stall back-pressure.
- Drains the datapath pipeline after the last beat, then returns a sticky done level to the sequencer's done vector.
- One instance per stage; non-reduce stages tie i_level to 0.

Parameters:
- LEVEL_WIDTH, 4, width of the reduce-level input.
- BASE_BEATS, 16, beats issued at level 0; must be a power of two and at least 1.
- CNT_WIDTH, 16, width of the beat counter and of o_beat_idx; must hold BASE_BEATS-1.
- PIPE_DEPTH, 3, drain cycles after the last beat; 0 is legal.
- TIMEOUT_CYCLES, 1024, watchdog limit, used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  single-cycle start pulse from the sequencer.
- i_level  in  LEVEL_WIDTH  reduce level, sampled only on an accepted start.
- i_stall  in  1  datapath back-pressure; no beat is issued while it is high.
- o_beat_valid  out  1  a beat is issued this cycle.
- o_beat_idx  out  CNT_WIDTH  index of the current beat, 0..N-1.
- o_beat_last  out  1  qualifies the final beat of the burst.
- o_busy  out  1  state is RUN or DRAIN.
- o_done  out  1  sticky done level returned to the sequencer.
- o_proto_err  out  1  sticky flag: start received while busy.
- o_timeout  out  1  sticky watchdog flag; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Burst length: N = BASE_BEATS >> i_level, floored at 1.
  - Any level >= log2(BASE_BEATS) gives N = 1.
  - N is latched at start and stays stable for the whole burst.
- State machine, states IDLE, RUN, DRAIN, DONE:
  - IDLE or DONE, i_start=1: go to RUN, latch N, clear the beat counter. o_done falls in the cycle after the start pulse.
  - RUN:
    - o_beat_valid = ~i_stall.
    - o_beat_idx = current beat counter value.
    - o_beat_last = o_beat_valid and (counter == N-1).
    - The counter increments only on an issued beat.
    - After the last beat is issued: go to DRAIN if PIPE_DEPTH>0, otherwise go to DONE.
  - DRAIN: counts PIPE_DEPTH cycles regardless of i_stall, then goes to DONE.
  - DONE: o_done=1, held until the next accepted start or reset.
- Latency with no stall, start at cycle T:
  - Beats issued at cycles T+1 .. T+N.
  - o_done high from cycle T+N+PIPE_DEPTH+1.
- Each stall cycle during RUN adds exactly one cycle to that latency.
- i_start during RUN or DRAIN:
  - The start is ignored and the burst continues unchanged.
  - o_proto_err is set and stays set until reset.
- i_start while already in DONE is a legal restart.
- o_busy = (state==RUN) | (state==DRAIN).
- Reset asserted mid-burst: all outputs drop to 0 asynchronously and no partial done is produced.

Optional Feature:
- Macro: STAGE_EXEC_TIMEOUT_EN.
- When defined:
  - A watchdog counts consecutive RUN cycles in which i_stall=1.
  - At TIMEOUT_CYCLES: o_timeout is set (sticky until reset), the burst is abandoned, the FSM goes directly to DONE, and o_done asserts so the sequencer does not hang.
  - The watchdog clears whenever a beat is issued.
- When undefined:
  - No watchdog logic is present.
  - o_timeout is tied to 0.
  - Stalls may extend RUN indefinitely.

Test Plan:
- Level 0, BASE_BEATS=16, PIPE_DEPTH=3, no stall, start at cycle 0 -> beats idx 0..15 on cycles 1..16, o_beat_last on cycle 16, o_done rises at cycle 20.
- Level 2, i_stall high on cycles 2-4 -> 4 beats, idx sequence 0,1,2,3 with no beat on cycles 2-4, o_done rises at cycle 11.
- Level 9 (saturation) -> single beat idx 0 with o_beat_last on cycle 1, o_done at cycle 5.
- Start pulse at cycle 6 of a level-0 burst -> burst unaffected, o_proto_err=1, o_done still at cycle 20.
- Restart from DONE at cycle 25 with level 1 -> o_done low from cycle 26, 8 beats on cycles 26..33, o_done again at cycle 37.
- With STAGE_EXEC_TIMEOUT_EN defined and TIMEOUT_CYCLES=8 -> i_stall held high from cycle 3 sets o_timeout and o_done by cycle 11. Without the macro, o_done stays 0 and o_timeout stays 0. Separately, rst_n low mid-burst clears all outputs immediately.
